noc_ejector: RTL and testbench

NOC_EJECTOR -- requirements
Module: noc_ejector

---
 rtl/noc_ejector_if.sv | 49 ++++
 rtl/noc_ejector.sv | 207 ++++++++++++++++++++
 tb/tb_noc_ejector.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/noc_ejector_if.sv
// Flit type package and the router/consumer-facing interface of the NoC ejector.
package noc_params;
    localparam int MESH_SIZE_X      = 4;
    localparam int MESH_SIZE_Y      = 4;
    localparam int VC_NUM           = 2;
    localparam int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int PAYLOAD_SIZE     = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [PAYLOAD_SIZE-1:0]     data;
    } flit_t;
endpackage

interface noc_ejector_if #(
    parameter int VC_NUM = noc_params::VC_NUM
);
    noc_params::flit_t data_i;
    logic              valid_flit_i;
    logic [VC_NUM-1:0] on_off_o;
    logic [VC_NUM-1:0] vc_allocatable_o;
    noc_params::flit_t flit_o;
    logic              flit_valid_o;
    logic              flit_ready_i;
    logic [VC_NUM-1:0] err_o;

    // master = router and consumer side, slave = the ejector itself
    modport master (
        output data_i, valid_flit_i, flit_ready_i,
        input  on_off_o, vc_allocatable_o, flit_o, flit_valid_o, err_o
    );

    modport slave (
        input  data_i, valid_flit_i, flit_ready_i,
        output on_off_o, vc_allocatable_o, flit_o, flit_valid_o, err_o
    );
endinterface

// File: rtl/noc_ejector.sv
// NoC ejector: per-VC framing check and FIFO, packet-atomic round-robin output stage.
// Define NOC_EJECTOR_DEST_CHECK_EN to drop head flits not addressed to (X_CURRENT, Y_CURRENT).
module noc_ejector #(
    parameter int VC_NUM      = noc_params::VC_NUM,
    parameter int BUFFER_SIZE = 8,
    parameter int X_CURRENT   = noc_params::MESH_SIZE_X / 2,
    parameter int Y_CURRENT   = noc_params::MESH_SIZE_Y / 2,
    parameter int OFF_MARGIN  = 2
) (
    input logic          clk,
    input logic          rst,
    noc_ejector_if.slave ej
);
    typedef noc_params::flit_t flit_t;

    localparam int PTR_W   = $clog2(BUFFER_SIZE);
    localparam int CNT_W   = PTR_W + 1;
    localparam int VC_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int VC_ID_W = noc_params::VC_SIZE;
    localparam int DX_W    = noc_params::DEST_ADDR_SIZE_X;
    localparam int DY_W    = noc_params::DEST_ADDR_SIZE_Y;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PKT  = 1'b1;

    if (BUFFER_SIZE < 2 || (BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0) begin : g_bad_buffer_size
        $error("noc_ejector: BUFFER_SIZE must be a power of two >= 2");
    end
    if (OFF_MARGIN < 1 || OFF_MARGIN > BUFFER_SIZE - 1) begin : g_bad_off_margin
        $error("noc_ejector: OFF_MARGIN must be in 1..BUFFER_SIZE-1");
    end
    if (VC_NUM < 2 || VC_NUM > (1 << VC_ID_W)) begin : g_bad_vc_num
        $error("noc_ejector: VC_NUM must be 2..2**VC_SIZE");
    end
    if (X_CURRENT < 0 || X_CURRENT >= noc_params::MESH_SIZE_X ||
        Y_CURRENT < 0 || Y_CURRENT >= noc_params::MESH_SIZE_Y) begin : g_bad_position
        $error("noc_ejector: X_CURRENT/Y_CURRENT outside the mesh");
    end

    flit_t            r_mem      [VC_NUM][BUFFER_SIZE];
    logic [PTR_W-1:0] r_wr_ptr   [VC_NUM];
    logic [PTR_W-1:0] r_rd_ptr   [VC_NUM];
    logic [CNT_W-1:0] r_count    [VC_NUM];
    logic [0:0]       r_state    [VC_NUM];
    logic [VC_NUM-1:0] r_err;
    logic [VC_NUM-1:0] r_on_off;

    flit_t            r_flit_o;
    logic             r_out_valid;
    logic [VC_W-1:0]  r_out_vc;
    logic             r_locked;
    logic [VC_W-1:0]  r_lock_vc;
    logic [VC_W-1:0]  r_rr_ptr;

    logic             w_is_head;
    logic             w_dest_ok;
    logic [VC_NUM-1:0] w_sel;
    logic [VC_NUM-1:0] w_legal;
    logic [VC_NUM-1:0] w_full;
    logic [VC_NUM-1:0] w_accept;
    logic [VC_NUM-1:0] w_drop;
    logic [VC_NUM-1:0] w_pop;
    logic [VC_NUM-1:0] w_avail;
    logic [CNT_W-1:0] w_count_next [VC_NUM];
    flit_t            w_head       [VC_NUM];
    logic             w_out_fire;
    logic             w_load;
    logic             w_grant_found;
    logic [VC_W-1:0]  w_grant_vc;
    logic [VC_W-1:0]  w_rr_vc;
    flit_t            w_grant_flit;

    assign w_is_head = (ej.data_i.flit_label == noc_params::HEAD) ||
                       (ej.data_i.flit_label == noc_params::HEADTAIL);

`ifdef NOC_EJECTOR_DEST_CHECK_EN
    assign w_dest_ok = !w_is_head ||
                       ((ej.data_i.x_dest == DX_W'(X_CURRENT)) &&
                        (ej.data_i.y_dest == DY_W'(Y_CURRENT)));
`else
    assign w_dest_ok = 1'b1;
`endif

    // Fullness uses pre-edge occupancy, so a same-cycle read never frees a slot for the writer.
    always_comb begin
        w_sel    = '0;
        w_legal  = '0;
        w_full   = '0;
        w_accept = '0;
        w_drop   = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_sel[v]    = ej.valid_flit_i && (ej.data_i.vc_id == VC_ID_W'(v));
            w_full[v]   = (r_count[v] == CNT_W'(BUFFER_SIZE));
            w_legal[v]  = (r_state[v] == S_IDLE) ? w_is_head : !w_is_head;
            w_accept[v] = w_sel[v] && w_legal[v] && w_dest_ok && !w_full[v];
            w_drop[v]   = w_sel[v] && !w_accept[v];
        end
    end

    assign w_out_fire = r_out_valid && ej.flit_ready_i;
    assign w_load     = !r_out_valid || ej.flit_ready_i;

    // The presented flit stays in its FIFO until consumed; the next candidate looks past it.
    always_comb begin
        w_pop         = '0;
        w_avail       = '0;
        w_grant_found = 1'b0;
        w_grant_vc    = '0;
        w_rr_vc       = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_pop[v]        = w_out_fire && (r_out_vc == VC_W'(v));
            w_avail[v]      = (r_count[v] > CNT_W'(w_pop[v]));
            w_head[v]       = r_mem[v][w_pop[v] ? (r_rd_ptr[v] + PTR_W'(1)) : r_rd_ptr[v]];
            w_count_next[v] = r_count[v] + CNT_W'(w_accept[v]) - CNT_W'(w_pop[v]);
        end
        if (r_locked) begin
            w_grant_found = w_avail[r_lock_vc];
            w_grant_vc    = r_lock_vc;
        end else begin
            for (int k = 1; k <= VC_NUM; k++) begin
                w_rr_vc = VC_W'((int'(r_rr_ptr) + k) % VC_NUM);
                if (!w_grant_found && w_avail[w_rr_vc]) begin
                    w_grant_found = 1'b1;
                    w_grant_vc    = w_rr_vc;
                end
            end
        end
        w_grant_flit = w_head[w_grant_vc];
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (w_accept[v]) begin
                r_mem[v][r_wr_ptr[v]] <= ej.data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
                r_state[v]  <= S_IDLE;
            end
            r_err    <= '0;
            r_on_off <= '1;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_accept[v]) begin
                    r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
                    if (ej.data_i.flit_label == noc_params::HEAD) begin
                        r_state[v] <= S_PKT;
                    end else if (ej.data_i.flit_label == noc_params::TAIL) begin
                        r_state[v] <= S_IDLE;
                    end
                end
                if (w_pop[v]) begin
                    r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
                end
                r_count[v] <= w_count_next[v];
                if (w_drop[v]) begin
                    r_err[v] <= 1'b1;
                end
                r_on_off[v] <= (CNT_W'(BUFFER_SIZE) - w_count_next[v]) > CNT_W'(OFF_MARGIN);
            end
        end
    end

    // A loaded HEAD or BODY means the packet's TAIL is still to come, so the grant stays locked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_flit_o    <= '0;
            r_out_vc    <= '0;
            r_locked    <= 1'b0;
            r_lock_vc   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_out_valid <= w_grant_found;
            if (w_grant_found) begin
                r_flit_o  <= w_grant_flit;
                r_out_vc  <= w_grant_vc;
                r_lock_vc <= w_grant_vc;
                r_locked  <= (w_grant_flit.flit_label == noc_params::HEAD) ||
                             (w_grant_flit.flit_label == noc_params::BODY);
                if (!r_locked) begin
                    r_rr_ptr <= w_grant_vc;
                end
            end
        end
    end

    always_comb begin
        ej.vc_allocatable_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            ej.vc_allocatable_o[v] = (r_state[v] == S_IDLE) && (r_count[v] == '0);
        end
    end

    assign ej.on_off_o     = r_on_off;
    assign ej.err_o        = r_err;
    assign ej.flit_o       = r_flit_o;
    assign ej.flit_valid_o = r_out_valid;

endmodule

// File: tb/tb_noc_ejector.sv
// Scoreboard bench for noc_ejector: stimulus pushes expected flits, a negedge monitor pops and compares.
module tb_noc_ejector;
    import noc_params::*;

    localparam int NUM_VC = noc_params::VC_NUM;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    noc_ejector_if #(.VC_NUM(NUM_VC)) ej ();

    noc_ejector #(
        .VC_NUM      (NUM_VC),
        .BUFFER_SIZE (8),
        .X_CURRENT   (2),
        .Y_CURRENT   (2),
        .OFF_MARGIN  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ej  (ej)
    );

    flit_t sb[$];
    int    popCycles[$];
    int    cycleCount = 0;
    int    popTotal   = 0;
    int    passCount  = 0;
    int    checkCount = 0;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic flit_t mkFlit(flit_label_t l, int vc, int x, int y, int d);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = VC_SIZE'(vc);
        f.x_dest     = DEST_ADDR_SIZE_X'(x);
        f.y_dest     = DEST_ADDR_SIZE_Y'(y);
        f.data       = PAYLOAD_SIZE'(d);
        return f;
    endfunction

    // Inputs change at posedge+1; the flit is captured at the following posedge.
    task automatic applyStimulus(input flit_t f, input bit expectOut);
        if (expectOut) sb.push_back(f);
        ej.data_i       = f;
        ej.valid_flit_i = 1'b1;
        @(posedge clk);
        #1;
        ej.valid_flit_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain(input string name);
        int budget;
        budget = 200;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checkOutput(name, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        flit_t expF;
        if (rst && ej.flit_valid_o && ej.flit_ready_i) begin
            popTotal++;
            popCycles.push_back(cycleCount);
            if (sb.size() == 0) begin
                checkOutput("unexpected_flit", 64'(ej.flit_valid_o), 64'd0);
            end else begin
                expF = sb.pop_front();
                checkOutput("flit_order", 64'(ej.flit_o), 64'(expF));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired passed=%0d total=%0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int firstWrite;
        int snap;
        logic [NUM_VC-1:0] expErr;

        ej.data_i       = '0;
        ej.valid_flit_i = 1'b0;
        ej.flit_ready_i = 1'b0;

        idle(3);
        checkOutput("rst_flit_valid", 64'(ej.flit_valid_o), 64'd0);
        checkOutput("rst_flit_o", 64'(ej.flit_o), 64'd0);
        checkOutput("rst_err", 64'(ej.err_o), 64'd0);
        checkOutput("rst_on_off", 64'(ej.on_off_o), 64'b11);
        checkOutput("rst_vc_alloc", 64'(ej.vc_allocatable_o), 64'b11);
        rst = 1'b1;
        idle(2);

        $display("[TB] 4-flit packet on VC0");
        ej.flit_ready_i = 1'b1;
        popCycles.delete();
        applyStimulus(mkFlit(HEAD, 0, 2, 2, 16'h1001), 1'b1);
        firstWrite = cycleCount;
        checkOutput("t1_vc_alloc_busy", 64'(ej.vc_allocatable_o[0]), 64'd0);
        applyStimulus(mkFlit(BODY, 0, 2, 2, 16'h1002), 1'b1);
        applyStimulus(mkFlit(BODY, 0, 2, 2, 16'h1003), 1'b1);
        applyStimulus(mkFlit(TAIL, 0, 2, 2, 16'h1004), 1'b1);
        waitDrain("t1_drain");
        checkOutput("t1_pop_count", 64'(popCycles.size()), 64'd4);
        checkOutput("t1_latency", 64'(popCycles[0]), 64'(firstWrite + 1));
        checkOutput("t1_back_to_back", 64'(popCycles[3] - popCycles[0]), 64'd3);
        checkOutput("t1_err", 64'(ej.err_o), 64'd0);
        checkOutput("t1_vc_alloc_idle", 64'(ej.vc_allocatable_o[0]), 64'd1);

        $display("[TB] interleaved packets on VC0 and VC1");
        sb.push_back(mkFlit(HEAD, 0, 2, 2, 16'h2001));
        sb.push_back(mkFlit(BODY, 0, 2, 2, 16'h2002));
        sb.push_back(mkFlit(TAIL, 0, 2, 2, 16'h2003));
        sb.push_back(mkFlit(HEAD, 1, 2, 2, 16'h3001));
        sb.push_back(mkFlit(BODY, 1, 2, 2, 16'h3002));
        sb.push_back(mkFlit(TAIL, 1, 2, 2, 16'h3003));
        applyStimulus(mkFlit(HEAD, 0, 2, 2, 16'h2001), 1'b0);
        applyStimulus(mkFlit(HEAD, 1, 2, 2, 16'h3001), 1'b0);
        applyStimulus(mkFlit(BODY, 0, 2, 2, 16'h2002), 1'b0);
        applyStimulus(mkFlit(BODY, 1, 2, 2, 16'h3002), 1'b0);
        applyStimulus(mkFlit(TAIL, 0, 2, 2, 16'h2003), 1'b0);
        applyStimulus(mkFlit(TAIL, 1, 2, 2, 16'h3003), 1'b0);
        waitDrain("t2_drain");
        checkOutput("t2_err", 64'(ej.err_o), 64'd0);

        $display("[TB] head addressed to (0,0)");
`ifdef NOC_EJECTOR_DEST_CHECK_EN
        applyStimulus(mkFlit(HEAD, 0, 0, 0, 16'h4001), 1'b0);
        applyStimulus(mkFlit(TAIL, 0, 0, 0, 16'h4002), 1'b0);
        expErr = 2'b01;
`else
        applyStimulus(mkFlit(HEAD, 0, 0, 0, 16'h4001), 1'b1);
        applyStimulus(mkFlit(TAIL, 0, 0, 0, 16'h4002), 1'b1);
        expErr = 2'b00;
`endif
        idle(4);
        waitDrain("t3_drain");
        checkOutput("t3_err", 64'(ej.err_o), 64'(expErr));

        $display("[TB] BODY to idle VC0");
        applyStimulus(mkFlit(BODY, 0, 2, 2, 16'h5001), 1'b0);
        idle(1);
        checkOutput("t4_err", 64'(ej.err_o), 64'b01);
        applyStimulus(mkFlit(HEADTAIL, 0, 2, 2, 16'h5002), 1'b1);
        waitDrain("t4_drain");

        $display("[TB] fill VC1 with consumer stalled");
        ej.flit_ready_i = 1'b0;
        applyStimulus(mkFlit(HEAD, 1, 2, 2, 16'h6000), 1'b1);
        checkOutput("t5_on_off_w1", 64'(ej.on_off_o[1]), 64'd1);
        for (int k = 2; k <= 8; k++) begin
            applyStimulus(mkFlit(BODY, 1, 2, 2, 16'h6000 + k), 1'b1);
            checkOutput($sformatf("t5_on_off_w%0d", k), 64'(ej.on_off_o[1]), 64'(k < 6));
        end
        checkOutput("t5_hold_valid", 64'(ej.flit_valid_o), 64'd1);
        checkOutput("t5_hold_flit", 64'(ej.flit_o), 64'(mkFlit(HEAD, 1, 2, 2, 16'h6000)));
        applyStimulus(mkFlit(BODY, 1, 2, 2, 16'h6009), 1'b0);
        checkOutput("t5_err_full", 64'(ej.err_o), 64'b11);
        checkOutput("t5_vc_alloc", 64'(ej.vc_allocatable_o), 64'b01);
        ej.flit_ready_i = 1'b1;
        idle(3);
        applyStimulus(mkFlit(TAIL, 1, 2, 2, 16'h600A), 1'b1);
        waitDrain("t5_drain");
        checkOutput("t5_on_off_back", 64'(ej.on_off_o), 64'b11);
        checkOutput("t5_vc_alloc_back", 64'(ej.vc_allocatable_o), 64'b11);

        $display("[TB] reset mid-packet");
        ej.flit_ready_i = 1'b0;
        applyStimulus(mkFlit(HEAD, 0, 2, 2, 16'h7001), 1'b0);
        applyStimulus(mkFlit(BODY, 0, 2, 2, 16'h7002), 1'b0);
        idle(1);
        rst = 1'b0;
        #1;
        checkOutput("t6_flit_valid", 64'(ej.flit_valid_o), 64'd0);
        checkOutput("t6_flit_o", 64'(ej.flit_o), 64'd0);
        checkOutput("t6_err", 64'(ej.err_o), 64'd0);
        checkOutput("t6_on_off", 64'(ej.on_off_o), 64'b11);
        checkOutput("t6_vc_alloc", 64'(ej.vc_allocatable_o), 64'b11);
        idle(2);
        rst = 1'b1;
        ej.flit_ready_i = 1'b1;
        snap = popTotal;
        idle(5);
        checkOutput("t6_quiet", 64'(popTotal - snap), 64'd0);
        applyStimulus(mkFlit(TAIL, 0, 2, 2, 16'h7003), 1'b0);
        idle(3);
        checkOutput("t6_quiet_tail", 64'(popTotal - snap), 64'd0);
        checkOutput("t6_err_tail", 64'(ej.err_o), 64'b01);
        applyStimulus(mkFlit(HEADTAIL, 0, 2, 2, 16'h7004), 1'b1);
        waitDrain("t6_drain");
        checkOutput("t6_pop_after", 64'(popTotal - snap), 64'd1);

        idle(2);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
